// File: rtl/aes_package.sv
// Shared constants and FSM state type for the AES block serializer.
package aes_package;

  localparam int unsigned AES_WORD_W   = 32;
  localparam int unsigned AES_NB_WORDS = 4;
  localparam int unsigned AES_BLOCK_W  = AES_WORD_W * AES_NB_WORDS;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready word stream interface (source drives valid/data/strb).
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/aes_block_serializer.sv
// Splits a WORD_W*NB_WORDS block into NB_WORDS stream words, LSB word first.
// Optional macro AES_SER_BACK2BACK_EN: accept the next block during the last
// word handshake so consecutive blocks stream without an idle bubble.
module aes_block_serializer
  import aes_package::*;
#(
  parameter int unsigned WORD_W   = AES_WORD_W,
  parameter int unsigned NB_WORDS = AES_NB_WORDS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic [WORD_W*NB_WORDS-1:0]   block_i,
  input  logic                         block_valid_i,
  output logic                         block_ready_o,
  hwpe_stream_intf_stream.source       aes_output,
  output logic                         busy_o,
  output logic [$clog2(NB_WORDS)-1:0]  beat_cnt_o,
  output logic                         done_o
);

  localparam int unsigned BLOCK_W = WORD_W * NB_WORDS;
  localparam int unsigned BEAT_W  = $clog2(NB_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB_WORDS - 1);

  ser_state_t          state_q, state_d;
  logic [BLOCK_W-1:0]  buffer_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                send;
  logic                out_hs;
  logic                capture;

  assign send    = (state_q == SEND);
  assign out_hs  = send & aes_output.ready;
  assign capture = block_valid_i & block_ready_o;

  // Next state, upstream ready and completion pulse; clear and reset override all.
  always_comb begin
    state_d       = state_q;
    block_ready_o = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        block_ready_o = 1'b1;
        if (block_valid_i) state_d = SEND;
      end
      SEND: begin
        if (aes_output.ready && (beat_q == LAST_BEAT)) begin
          done_o = 1'b1;
`ifdef AES_SER_BACK2BACK_EN
          block_ready_o = 1'b1;
          if (!block_valid_i) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d       = IDLE;
      block_ready_o = 1'b0;
      done_o        = 1'b0;
    end
    // State is already IDLE under reset; this keeps ready low while rst_i is high.
    if (rst_i) begin
      block_ready_o = 1'b0;
      done_o        = 1'b0;
    end
  end

  // State register, block buffer and beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      buffer_q <= '0;
      beat_q   <= '0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      buffer_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        buffer_q <= block_i;
        beat_q   <= '0;
      end else if (out_hs) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
    end
  end

  assign aes_output.valid = send;
  assign aes_output.data  = send ? buffer_q[beat_q*WORD_W +: WORD_W] : '0;
  assign aes_output.strb  = send ? '1 : '0;
  assign busy_o           = send;
  assign beat_cnt_o       = beat_q;

endmodule

// File: doc/aes_block_serializer.md
AES_BLOCK_SERIALIZER -- requirements
Module: aes_block_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output stream data width in bits.
REQ-002 SHALL have parameter NB_WORDS, default 4, meaning words per block; block width = WORD_W*NB_WORDS.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port clear_i  input  1  synchronous flush, active-high.
REQ-006 SHALL have port block_i  input  WORD_W*NB_WORDS  block to transmit.
REQ-007 SHALL have port block_valid_i  input  1  block_i is valid.
REQ-008 SHALL have port block_ready_o  output  1  serializer accepts block_i this cycle.
REQ-009 SHALL have port aes_output  hwpe_stream_intf_stream.source  data WORD_W, strb WORD_W/8  serialized word stream.
REQ-010 SHALL have port busy_o  output  1  high while a block is held or being sent.
REQ-011 SHALL have port beat_cnt_o  output  $clog2(NB_WORDS)  index of the word currently presented.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse when the last word of a block is accepted.

Function
REQ-013 SHALL implement FSM states IDLE and SEND.
REQ-014 SHALL assert block_ready_o in IDLE only; block_valid_i & block_ready_o captures block_i into a buffer, clears beat count to 0, and enters SEND.
REQ-015 SHALL, in SEND, drive aes_output.valid=1, aes_output.data=buffer[beat*WORD_W +: WORD_W] and aes_output.strb='1.
REQ-016 SHALL emit word 0 (bits [WORD_W-1:0]) first and word NB_WORDS-1 (MSBs) last.
REQ-017 SHALL hold data and valid stable while valid & !ready; valid never drops before handshake.
REQ-018 SHALL advance beat by 1 on each aes_output.valid & aes_output.ready.
REQ-019 SHALL, on handshake at beat NB_WORDS-1, pulse done_o for that cycle, wrap beat to 0, and return to IDLE.
REQ-020 SHALL give a first-word latency of one cycle: word 0 valid in the cycle after block capture.
REQ-021 SHALL drive aes_output.valid=0 and data='0 in IDLE.
REQ-022 SHALL, when clear_i is high, enter IDLE, zero the buffer and beat count, and suppress done_o; clear_i wins over every simultaneous handshake.
REQ-023 SHALL ignore block_valid_i while in SEND; the buffer is not overwritten.
REQ-024 SHALL drive busy_o = (state==SEND).

Reset
REQ-025 SHALL, while rst_i is high, hold state IDLE, buffer '0, beat 0.
REQ-026 SHALL hold aes_output.valid=0, block_ready_o=0, busy_o=0, done_o=0 and beat_cnt_o=0 while rst_i is high, including when reset is asserted mid-block.
REQ-027 SHALL discard a partially sent block on reset; no resume after rst_i falls.

Configuration
REQ-028 SHALL support macro AES_SER_BACK2BACK_EN.
REQ-029 SHALL, with AES_SER_BACK2BACK_EN defined, also assert block_ready_o in SEND during the cycle the last word handshakes; a block captured then stays in SEND with beat 0 and no idle bubble.
REQ-030 SHALL, without the macro, force at least one IDLE cycle (block_ready_o=1, valid=0) between blocks.

Structure
REQ-031 SHALL take AES_WORD_W=32, AES_NB_WORDS=4, AES_BLOCK_W=128 and enum ser_state_t {IDLE, SEND} from aes_package.
REQ-032 SHALL be a single module with no sub-module; FSM, counter and buffer are inline.

Verification
REQ-033 SHALL cover: block 0x33333333_22222222_11111111_00000000 with ready=1 -> words 0x00000000, 0x11111111, 0x22222222, 0x33333333 on 4 consecutive cycles; done_o high with the 4th.
REQ-034 SHALL cover: same block with ready low for 3 cycles at beat 2 -> 0x22222222 held stable with valid high; no beat skipped or repeated.
REQ-035 SHALL cover: clear_i at beat 1 -> valid=0 next cycle, state IDLE, done_o never pulses; next block starts at word 0.
REQ-036 SHALL cover: rst_i asserted mid-beat 2 -> valid and busy_o drop immediately; after release, block_ready_o=1 and no stale words appear.
REQ-037 SHALL cover: two back-to-back blocks -> with AES_SER_BACK2BACK_EN 8 words in 8 cycles; without it 8 words in 9 cycles.
REQ-038 SHALL cover: block_valid_i toggled during SEND with new data -> ignored; the original 4 words go out unchanged.
